alu_wb_stage: RTL and testbench
===============================

Name: alu_wb_stage

Overview:
- Execute/writeback stage directly downstream of the 32x32 three-port register file (`regs`).
- Takes the two read-port outputs (`rdata1`/`rdata2`) for an accepted operation and computes a 32-bit result.
- Drives the register file's write port (`write`/`wreg`/`wdata`) one cycle later.
- Includes a write-to-read bypass and an iterative shift-add multiplier controlled by a small FSM.

Parameters:
- WIDTH, 32, datapath width; must match the register file data width.
- AW, 5, register address width (32 registers).
- MUL_CYCLES, 32, multiplier iterations; must equal WIDTH.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operation request.
- in_ready  out  1  stage can accept; an operation is accepted when in_valid && in_ready.
- op  in  4  opcode.
- rs1  in  AW  source register 1; also drives the register file `regno1`.
- rs2  in  AW  source register 2; also drives the register file `regno2`.
- rd  in  AW  destination register.
- rdata1  in  WIDTH  read data 1 from the register file (combinational read).
- rdata2  in  WIDTH  read data 2 from the register file.
- write  out  1  register file write enable, registered.
- wreg  out  AW  register file write address, registered.
- wdata  out  WIDTH  register file write data, registered.
- err  out  1  one-cycle pulse on an illegal opcode.

Behaviour:
- Reset (async, while rst=1):
  - state=IDLE; write=0, wreg=0, wdata=0, err=0.
  - Multiplier counter, accumulator and operand registers cleared.
  - in_ready=0 while rst=1.
  - Reset asserted mid-multiply abandons the operation; no write is issued.
- Opcodes:
  - 0 NOP (no write).
  - 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR.
  - 6 SLL (A << B[4:0]), 7 SRL (logical, A >> B[4:0]).
  - 8 SLT (signed A<B gives 1, else 0).
  - 9 MOV (result = B).
  - 10 MUL (low 32 bits of A*B, unsigned).
  - 11-15 illegal.
- Arithmetic is modulo 2^32; no carry or overflow is reported.
- Operand bypass, per operand and independent:
  - A = (write && wreg==rs1) ? wdata : rdata1.
  - B = (write && wreg==rs2) ? wdata : rdata2.
  - Needed because the register file commits on the same edge at which the stage samples. Register 0 is an ordinary register and is bypassed like any other.
- FSM states: IDLE, MUL.
  - IDLE: in_ready=1.
    - Accept of a single-cycle op: next edge sets write=1, wreg=rd, wdata=result. Latency is 1 cycle and throughput 1 per cycle (back-to-back accepts give consecutive write pulses).
    - Accept of NOP: next edge write=0.
    - Accept of an illegal opcode: next edge write=0, err=1 for one cycle.
    - No accept: next edge write=0, err=0.
  - IDLE to MUL on accept of MUL:
    - Latch mcand=A, mplier=B, acc=0, cnt=0, rd.
    - The following edge drives write=0.
  - MUL: in_ready=0, write=0. Each edge:
    - if mplier[0] then acc += mcand;
    - mcand <<= 1; mplier >>= 1; cnt++.
  - MUL to IDLE: on the edge where cnt==MUL_CYCLES-1, load write=1, wreg=rd, wdata=final acc. Accept at edge T gives write asserted after edge T+32.
  - in_ready returns to 1 in the cycle where that write is visible; the bypass covers an immediately dependent operation.
- in_valid while in_ready=0 is ignored and no state changes. The upstream stage holds its request.

Optional Feature:
- Macro ALU_MUL_EN.
- Defined: MUL implemented as above, with the MUL state, counter and accumulator present.
- Undefined: no MUL state or datapath. Opcode 10 is treated as illegal (write=0, err pulse) and in_ready stays 1 outside reset.

Test Plan:
- Reset release, then accept ADD with rs1=0/rs2=4, rdata1=0x0B, rdata2=0x05, rd=8 -> next cycle write=1, wreg=8, wdata=0x10.
- Back-to-back: ADD rd=6 (result 3), then in the next cycle MOV rs2=6 with stale rdata2=0 -> second write wdata=3 (bypass used), consecutive write pulses.
- SUB 0x0 - 0x1 -> wdata=0xFFFFFFFF. SLT signed 0xFFFFFFFF<0x1 -> wdata=1. SRL 0x80000000 by 31 -> wdata=1.
- MUL 0x0000FFFF*0x00010001 (ALU_MUL_EN defined) -> in_ready=0 for 32 cycles, in_valid ignored, then write=1 with wdata=0xFFFFFFFF. Repeat with the macro undefined -> err=1, write=0.
- Opcode 12 -> err=1 for exactly one cycle, write=0; NOP -> err=0, write=0.
- Assert rst 10 cycles into a MUL -> write=0, wdata=0 immediately (asynchronous). After release, in_ready=1 and no stale write occurs.

Source files
------------

// File: rtl/alu_wb_stage.sv
// alu_wb_stage: execute/writeback stage sitting after the 3-port register file.
// Computes a result from the two read ports and drives the write port one
// cycle later. Both operands are bypassed from the pending write.
// Optional feature macro: ALU_MUL_EN enables the iterative shift-add MUL
// (opcode 10). When it is not defined, opcode 10 is reported as illegal.
module alu_wb_stage #(
  parameter int WIDTH      = 32,
  parameter int AW         = 5,
  parameter int MUL_CYCLES = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [AW-1:0]    rs1,
  input  logic [AW-1:0]    rs2,
  input  logic [AW-1:0]    rd,
  input  logic [WIDTH-1:0] rdata1,
  input  logic [WIDTH-1:0] rdata2,
  output logic             write,
  output logic [AW-1:0]    wreg,
  output logic [WIDTH-1:0] wdata,
  output logic             err
);

  logic             write_q, write_d;
  logic [AW-1:0]    wreg_q, wreg_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] op_a, op_b, alu_res;
  logic             alu_legal, alu_wr, accept;

  // The register file commits on the same edge we sample, so forward the
  // pending write into either operand. Register 0 is not special here.
  assign op_a   = (write_q && (wreg_q == rs1)) ? wdata_q : rdata1;
  assign op_b   = (write_q && (wreg_q == rs2)) ? wdata_q : rdata2;
  assign accept = in_valid && in_ready;

  // Single-cycle result and opcode classification.
  always_comb begin
    alu_res   = '0;
    alu_legal = 1'b1;
    alu_wr    = 1'b1;
    case (op)
      4'd0: alu_wr  = 1'b0;
      4'd1: alu_res = op_a + op_b;
      4'd2: alu_res = op_a - op_b;
      4'd3: alu_res = op_a & op_b;
      4'd4: alu_res = op_a | op_b;
      4'd5: alu_res = op_a ^ op_b;
      4'd6: alu_res = op_a << op_b[4:0];
      4'd7: alu_res = op_a >> op_b[4:0];
      4'd8: alu_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      4'd9: alu_res = op_b;
`ifdef ALU_MUL_EN
      4'd10: alu_wr = 1'b0;  // result comes later from the multiplier FSM
`endif
      default: begin
        alu_legal = 1'b0;
        alu_wr    = 1'b0;
      end
    endcase
  end

`ifdef ALU_MUL_EN
  localparam int CW = $clog2(MUL_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(MUL_CYCLES - 1);
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_MUL  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d, acc_add;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [AW-1:0]    mrd_q, mrd_d;

  assign in_ready = ~rst && (state_q == ST_IDLE);
  assign acc_add  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

  // Next-state logic: issue single-cycle ops from IDLE, iterate in MUL.
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    mrd_d    = mrd_q;
    write_d  = 1'b0;
    err_d    = 1'b0;
    wreg_d   = wreg_q;
    wdata_d  = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (op == 4'd10) begin
            state_d  = ST_MUL;
            mcand_d  = op_a;
            mplier_d = op_b;
            acc_d    = '0;
            cnt_d    = '0;
            mrd_d    = rd;
          end else if (alu_wr) begin
            write_d = 1'b1;
            wreg_d  = rd;
            wdata_d = alu_res;
          end else if (!alu_legal) begin
            err_d = 1'b1;
          end
        end
      end
      default: begin
        acc_d    = acc_add;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
          write_d = 1'b1;
          wreg_d  = mrd_q;
          wdata_d = acc_add;
        end
      end
    endcase
  end

  // Multiplier state; reset abandons any multiply in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      mrd_q    <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      mrd_q    <= mrd_d;
    end
  end
`else
  assign in_ready = ~rst;

  // Next-state logic: every op completes in one cycle; opcode 10 is illegal.
  always_comb begin
    write_d = 1'b0;
    err_d   = 1'b0;
    wreg_d  = wreg_q;
    wdata_d = wdata_q;
    if (accept) begin
      if (alu_wr) begin
        write_d = 1'b1;
        wreg_d  = rd;
        wdata_d = alu_res;
      end else if (!alu_legal) begin
        err_d = 1'b1;
      end
    end
  end
`endif

  // Registered write port and error pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      write_q <= 1'b0;
      wreg_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      write_q <= write_d;
      wreg_q  <= wreg_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  assign write = write_q;
  assign wreg  = wreg_q;
  assign wdata = wdata_q;
  assign err   = err_q;

endmodule

// File: tb/tb_alu_wb_stage.sv
// Scoreboard bench for alu_wb_stage: stimulus pushes expected write/err
// events, a negedge monitor pops and compares whenever write or err is seen.
// MUL-specific vectors follow the ALU_MUL_EN macro.
module tb_alu_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] rdata1, rdata2;
  logic        write;
  logic [4:0]  wreg;
  logic [31:0] wdata;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        is_err;
    logic [4:0]  wr_reg;
    logic [31:0] data;
    string       name;
  } exp_t;

  exp_t exp_q[$];

  alu_wb_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .rs1(rs1), .rs2(rs2), .rd(rd),
    .rdata1(rdata1), .rdata2(rdata2),
    .write(write), .wreg(wreg), .wdata(wdata), .err(err)
  );

  always #5 clk = ~clk;

  // Monitor: every write or err cycle must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && (write || err)) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_output: got write=%0b err=%0b wreg=%0d wdata=%h, required no output",
                 write, err, wreg, wdata);
      end else begin
        exp_t e;
        logic ok;
        e = exp_q.pop_front();
        if (e.is_err) ok = err && !write;
        else          ok = write && !err && (wreg == e.wr_reg) && (wdata == e.data);
        if (!ok) begin
          n_fail++;
          $display("FAIL %s: got write=%0b err=%0b wreg=%0d wdata=%h, required %s wreg=%0d wdata=%h",
                   e.name, write, err, wreg, wdata, e.is_err ? "err" : "write", e.wr_reg, e.data);
        end else begin
          $display("ok   %s: write=%0b err=%0b wreg=%0d wdata=%h", e.name, write, err, wreg, wdata);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic expect_wr(input string name, input logic [4:0] r, input logic [31:0] d);
    exp_t e;
    e.is_err = 1'b0; e.wr_reg = r; e.data = d; e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic expect_err(input string name);
    exp_t e;
    e.is_err = 1'b1; e.wr_reg = '0; e.data = '0; e.name = name;
    exp_q.push_back(e);
  endtask

  // Present one request for a single edge (caller guarantees in_ready).
  task automatic issue(input logic [3:0] o, input logic [4:0] a1, input logic [4:0] a2,
                       input logic [4:0] d, input logic [31:0] r1, input logic [31:0] r2);
    in_valid = 1'b1; op = o; rs1 = a1; rs2 = a2; rd = d; rdata1 = r1; rdata2 = r2;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int stall;
    rst = 1'b1; in_valid = 1'b0; op = '0; rs1 = '0; rs2 = '0; rd = '0;
    rdata1 = '0; rdata2 = '0;
    idle(2);
    chk("reset_write", {31'd0, write}, 32'd0);
    chk("reset_wreg", {27'd0, wreg}, 32'd0);
    chk("reset_wdata", wdata, 32'd0);
    chk("reset_err", {31'd0, err}, 32'd0);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b0;
    #1;
    chk("ready_after_reset", {31'd0, in_ready}, 32'd1);
    idle(1);

    // ADD 0x0B + 0x05 -> r8
    expect_wr("add_basic", 5'd8, 32'h10);
    issue(4'd1, 5'd0, 5'd4, 5'd8, 32'h0B, 32'h05);
    idle(1);

    // Back-to-back: ADD r6=3, then MOV from r6 with stale rdata2 (rs2 bypass)
    expect_wr("add_r6", 5'd6, 32'd3);
    expect_wr("mov_bypass_rs2", 5'd7, 32'd3);
    issue(4'd1, 5'd1, 5'd2, 5'd6, 32'd1, 32'd2);
    issue(4'd9, 5'd3, 5'd6, 5'd7, 32'h55, 32'd0);
    idle(1);

    // Register 0 written then used on rs1 next cycle (rs1 bypass)
    expect_wr("add_r0", 5'd0, 32'd5);
    expect_wr("add_bypass_rs1_r0", 5'd12, 32'd6);
    issue(4'd1, 5'd9, 5'd10, 5'd0, 32'd2, 32'd3);
    issue(4'd1, 5'd0, 5'd11, 5'd12, 32'h100, 32'd1);
    idle(1);

    expect_wr("sub_wrap", 5'd1, 32'hFFFF_FFFF);
    issue(4'd2, 5'd9, 5'd10, 5'd1, 32'd0, 32'd1);
    idle(1);
    expect_wr("slt_signed", 5'd2, 32'd1);
    issue(4'd8, 5'd9, 5'd10, 5'd2, 32'hFFFF_FFFF, 32'd1);
    idle(1);
    expect_wr("slt_false", 5'd2, 32'd0);
    issue(4'd8, 5'd9, 5'd10, 5'd2, 32'd1, 32'hFFFF_FFFF);
    idle(1);
    expect_wr("srl_31", 5'd3, 32'd1);
    issue(4'd7, 5'd9, 5'd10, 5'd3, 32'h8000_0000, 32'd31);
    idle(1);
    expect_wr("and", 5'd4, 32'h0000_F000);
    issue(4'd3, 5'd9, 5'd10, 5'd4, 32'h0000_F0F0, 32'h0000_FF00);
    idle(1);
    expect_wr("or", 5'd5, 32'h0000_00FF);
    issue(4'd4, 5'd9, 5'd10, 5'd5, 32'h0000_000F, 32'h0000_00F0);
    idle(1);
    expect_wr("xor", 5'd9, 32'h0000_00F0);
    issue(4'd5, 5'd1, 5'd2, 5'd9, 32'h0000_00FF, 32'h0000_000F);
    idle(1);
    expect_wr("sll_low5", 5'd10, 32'h0000_0010);
    issue(4'd6, 5'd1, 5'd2, 5'd10, 32'd1, 32'h24);
    idle(1);

    // Illegal opcode 12, then NOP: only one err cycle, no writes
    expect_err("illegal_op12");
    issue(4'd12, 5'd1, 5'd2, 5'd11, 32'd7, 32'd7);
    idle(2);
    issue(4'd0, 5'd1, 5'd2, 5'd11, 32'd7, 32'd7);
    idle(2);

`ifdef ALU_MUL_EN
    // MUL: 32 stalled cycles with a held request that must be ignored
    expect_wr("mul_result", 5'd13, 32'hFFFF_FFFF);
    issue(4'd10, 5'd1, 5'd2, 5'd13, 32'h0000_FFFF, 32'h0001_0001);
    in_valid = 1'b1; op = 4'd1; rs1 = 5'd20; rs2 = 5'd21; rd = 5'd14;
    rdata1 = 32'd1; rdata2 = 32'd1;
    stall = 0;
    while (!in_ready && stall < 100) begin
      stall++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("mul_stall_cycles", stall, 32'd32);
    idle(2);
`else
    expect_err("mul_disabled_illegal");
    issue(4'd10, 5'd1, 5'd2, 5'd13, 32'h0000_FFFF, 32'h0001_0001);
    chk("ready_after_op10", {31'd0, in_ready}, 32'd1);
    idle(2);
`endif

    // Asynchronous reset while a write is being presented (no expectation pushed)
    issue(4'd1, 5'd22, 5'd23, 5'd15, 32'h1234_0000, 32'h0000_5678);
    rst = 1'b1;
    #1;
    chk("async_rst_write", {31'd0, write}, 32'd0);
    chk("async_rst_wdata", wdata, 32'd0);
    chk("async_rst_wreg", {27'd0, wreg}, 32'd0);
    idle(1);
    rst = 1'b0;
    idle(1);

`ifdef ALU_MUL_EN
    // Leave a nonzero wdata, start a MUL, and reset 10 cycles in
    expect_wr("pre_mul_add", 5'd16, 32'h0000_0003);
    issue(4'd1, 5'd1, 5'd2, 5'd16, 32'd1, 32'd2);
    issue(4'd10, 5'd3, 5'd4, 5'd17, 32'd3, 32'd5);
    idle(10);
    rst = 1'b1;
    #1;
    chk("mul_rst_write", {31'd0, write}, 32'd0);
    chk("mul_rst_wdata", wdata, 32'd0);
    chk("mul_rst_in_ready", {31'd0, in_ready}, 32'd0);
    idle(1);
    rst = 1'b0;
    #1;
    chk("mul_rst_ready_after", {31'd0, in_ready}, 32'd1);
    idle(40);
`else
    idle(3);
`endif

    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
